// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants and types for the two-port round-robin SRAM arbiter.
// The macro geometry matches sky130_sram_1rw_tiny.
package sram_arb_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 9;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   localparam logic [MASK_W-1:0] WMASK_ALL = '1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

endpackage

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request
// vector plus a one-bit pointer naming the port favoured on contention.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   // 0 favours port 0, 1 favours port 1
   logic r_ptr;

   // Grant the lone requester, or the favoured one when both request
   always_comb begin
      grant = '0;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
         default: grant = '0;
      endcase
   end

   // After a handshake the other port becomes the favoured one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (accept && (grant != 2'b00)) begin
         r_ptr <= grant[0];
      end
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port SRAM macro between two requesters with
// round-robin arbitration, one access per clock. Macro inputs are driven
// combinationally from the granted request; read data is returned on a
// per-port strobe one cycle after the accept edge.
// Optional build macro SRAM_ARB_INIT_CLEAR_EN: after reset, clear every
// word to zero before accepting requests (busy high meanwhile).
module sram_rr_arbiter
   import sram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [MASK_W-1:0] req0_wmask,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [MASK_W-1:0] req1_wmask,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              sram_csb,
   output logic              sram_web,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              busy
);

   // Low while reset is asserted and until the first edge after release,
   // so every output shows its reset value without combinational use of rst_n
   logic              r_live;
   logic [1:0]        r_rsp_valid;
   logic              w_run;
   logic              w_init_wr;
   logic [ADDR_W-1:0] w_init_addr;
   logic [1:0]        w_valid;
   logic [1:0]        w_grant;
   logic              w_accept;

   // Release the datapath on the first edge after reset deasserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

`ifdef SRAM_ARB_INIT_CLEAR_EN
   state_t            r_state;
   logic [ADDR_W-1:0] r_init_addr;

   // Clear sweep: one zero write per cycle, then hand over to RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_init_addr <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_live) begin
                  if (r_init_addr == ADDR_W'(DEPTH - 1)) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_init_addr <= r_init_addr + 1'b1;
                  end
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign w_run       = r_live && (r_state == ST_RUN);
   assign w_init_wr   = r_live && (r_state == ST_INIT);
   assign w_init_addr = r_init_addr;
   assign busy        = (r_state == ST_INIT);
`else
   assign w_run       = r_live;
   assign w_init_wr   = 1'b0;
   assign w_init_addr = '0;
   assign busy        = 1'b0;
`endif

   assign w_valid  = {req1_valid, req0_valid} & {2{w_run}};
   assign w_accept = |w_grant;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (w_valid),
      .accept (w_accept),
      .grant  (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];

   // Macro drive: clear sweep, granted request, or idle
   always_comb begin
      sram_csb   = 1'b1;
      sram_web   = 1'b1;
      sram_wmask = '0;
      sram_addr  = '0;
      sram_din   = '0;
      if (w_init_wr) begin
         sram_csb   = 1'b0;
         sram_web   = 1'b0;
         sram_wmask = WMASK_ALL;
         sram_addr  = w_init_addr;
      end else if (w_grant[0]) begin
         sram_csb   = 1'b0;
         sram_web   = ~req0_we;
         sram_wmask = req0_we ? req0_wmask : '0;
         sram_addr  = req0_addr;
         sram_din   = req0_wdata;
      end else if (w_grant[1]) begin
         sram_csb   = 1'b0;
         sram_web   = ~req1_we;
         sram_wmask = req1_we ? req1_wmask : '0;
         sram_addr  = req1_addr;
         sram_din   = req1_wdata;
      end
   end

   // Flag an accepted read so its port sees data in the following cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= '0;
      end else begin
         r_rsp_valid <= {w_grant[1] & ~req1_we, w_grant[0] & ~req0_we};
      end
   end

   assign rsp0_valid = r_rsp_valid[0];
   assign rsp1_valid = r_rsp_valid[1];
   assign rsp0_rdata = r_rsp_valid[0] ? sram_dout : '0;
   assign rsp1_rdata = r_rsp_valid[1] ? sram_dout : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter with a behavioural SRAM macro and a
// transaction-level reference model of arbitration and memory contents.
module tb_sram_rr_arbiter;
   import sram_arb_pkg::*;

`ifdef SRAM_ARB_INIT_CLEAR_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic              v   [2];
   logic              we  [2];
   logic [ADDR_W-1:0] a   [2];
   logic [DATA_W-1:0] d   [2];
   logic [MASK_W-1:0] m   [2];
   logic              rdy [2];
   logic              rv  [2];
   logic [DATA_W-1:0] rd  [2];

   logic              csb, web, busy;
   logic [MASK_W-1:0] wmask;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int                port;
      logic [DATA_W-1:0] data;
      time               due;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   sram_rr_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v[0]),
      .req0_ready (rdy[0]),
      .req0_we    (we[0]),
      .req0_addr  (a[0]),
      .req0_wdata (d[0]),
      .req0_wmask (m[0]),
      .req1_valid (v[1]),
      .req1_ready (rdy[1]),
      .req1_we    (we[1]),
      .req1_addr  (a[1]),
      .req1_wdata (d[1]),
      .req1_wmask (m[1]),
      .rsp0_valid (rv[0]),
      .rsp0_rdata (rd[0]),
      .rsp1_valid (rv[1]),
      .rsp1_rdata (rd[1]),
      .sram_csb   (csb),
      .sram_web   (web),
      .sram_wmask (wmask),
      .sram_addr  (addr),
      .sram_din   (din),
      .sram_dout  (dout),
      .busy       (busy)
   );

   // Lane map of the 9-bit word: three 2-bit lanes, top lane 3 bits wide
   function automatic logic [DATA_W-1:0] lane_bits(input logic [MASK_W-1:0] mk);
      return {{3{mk[3]}}, {2{mk[2]}}, {2{mk[1]}}, {2{mk[0]}}};
   endfunction

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return DATA_W'(i * 37 + 5);
   endfunction

   // Behavioural single-port macro: captures on the rising edge
   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic              mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else if (!csb) begin
         if (!web)
            sram_mem[addr] <= (sram_mem[addr] & ~lane_bits(wmask)) | (din & lane_bits(wmask));
         else
            dout <= sram_mem[addr];
      end
   end

   // Reference model: decides each cycle who should win and what the macro sees
   initial begin
      logic [DATA_W-1:0] ref_mem [DEPTH];
      bit  live_m, init_m;
      int  fav, g, icnt;
      logic [22:0] e_vec, a_vec;
      logic        e_r0, e_r1, e_csb, e_web, e_busy;
      logic [MASK_W-1:0] e_wm;
      logic [ADDR_W-1:0] e_ad;
      logic [DATA_W-1:0] e_din;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
      live_m = 0; init_m = INIT_EN; fav = 0; icnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            live_m = 0; init_m = INIT_EN; fav = 0; icnt = 0;
            continue;
         end
         e_busy = init_m;
         e_r0 = 0; e_r1 = 0; e_csb = 1; e_web = 1; e_wm = '0; e_ad = '0; e_din = '0;
         g = -1;
         if (live_m && init_m) begin
            e_csb = 0; e_web = 0; e_wm = '1; e_ad = ADDR_W'(icnt);
            ref_mem[icnt] = '0;
            icnt++;
            if (icnt == int'(DEPTH)) init_m = 0;
         end else if (live_m) begin
            if (v[0] && v[1]) g = fav;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
            if (g >= 0) begin
               e_r0  = (g == 0);
               e_r1  = (g == 1);
               e_csb = 0;
               e_web = !we[g];
               e_ad  = a[g];
               e_din = d[g];
               e_wm  = we[g] ? m[g] : '0;
               if (we[g])
                  ref_mem[a[g]] = (ref_mem[a[g]] & ~lane_bits(m[g])) | (d[g] & lane_bits(m[g]));
               else
                  exp_q.push_back('{port: g, data: ref_mem[a[g]], due: $time + 10});
               fav = 1 - g;
            end
         end
         e_vec = {e_r1, e_r0, e_csb, e_web, e_wm, e_ad, e_din, e_busy};
         a_vec = {rdy[1], rdy[0], csb, web, wmask, addr, din, busy};
         checks++;
         if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL outputs t=%0t {rdy1,rdy0,csb,web,wmask,addr,din,busy} act=%h exp=%h",
                     $time, a_vec, e_vec);
         end
         live_m = 1;
      end
   end

   // Monitor: every cycle, compare response strobes/data with the scoreboard
   initial begin
      bit exp_now;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         while (exp_q.size() > 0 && exp_q[0].due < $time) void'(exp_q.pop_front());
         for (int p = 0; p < 2; p++) begin
            exp_now = (exp_q.size() > 0) && (exp_q[0].due == $time) && (exp_q[0].port == p);
            checks++;
            if (rv[p] !== exp_now) begin
               errors++;
               $display("FAIL rsp%0d_valid t=%0t act=%b exp=%b", p, $time, rv[p], exp_now);
            end
            checks++;
            if (exp_now) begin
               if (rd[p] !== exp_q[0].data) begin
                  errors++;
                  $display("FAIL rsp%0d_rdata t=%0t act=%h exp=%h", p, $time, rd[p], exp_q[0].data);
               end
               void'(exp_q.pop_front());
            end else if (rd[p] !== '0) begin
               errors++;
               $display("FAIL rsp%0d_rdata_idle t=%0t act=%h exp=0", p, $time, rd[p]);
            end
         end
      end
   end

   // Issue one request (called just after a rising edge), hold until accepted
   task automatic do_req(input int p, input logic w, input logic [ADDR_W-1:0] ad,
                         input logic [DATA_W-1:0] dt, input logic [MASK_W-1:0] mk);
      bit ok = 0;
      v[p] = 1'b1; we[p] = w; a[p] = ad; d[p] = dt; m[p] = mk;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rdy[p]) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL handshake_timeout port=%0d ready act=0 exp=1", p);
      end
      @(posedge clk); #1;
      v[p] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [22:0] act, exp;
      act = {rdy[1], rdy[0], csb, web, wmask, addr, din, busy};
      exp = {1'b0, 1'b0, 1'b1, 1'b1, {MASK_W{1'b0}}, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, INIT_EN};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s outputs act=%h exp=%h", tag, act, exp);
      end
      checks++;
      if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp_valid act=%b%b exp=00", tag, rv[1], rv[0]);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("reset_async");
      repeat (2) begin
         @(negedge clk);
         check_reset_outputs("reset_hold");
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Stimulus sequence
   initial begin
      for (int p = 0; p < 2; p++) begin
         v[p] = 0; we[p] = 0; a[p] = '0; d[p] = '0; m[p] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("power_on_reset");
      rst_n = 1'b1;

      // Single write then read on port 0
      do_req(0, 1'b1, 5'd5, 9'h1A5, 4'hF);
      do_req(0, 1'b0, 5'd5, 9'h000, 4'h0);
      idle(2);

      // Contention from reset: both ports stream reads
      @(posedge clk); #1;
      apply_reset();
      fork
         begin
            for (int i = 0; i < 3; i++) do_req(0, 1'b0, ADDR_W'(i), '0, '0);
         end
         begin
            for (int i = 0; i < 3; i++) do_req(1, 1'b0, ADDR_W'(i + 8), '0, '0);
         end
      join
      idle(1);

      // Lone port-0 request leaves port 1 favoured across an idle gap
      do_req(0, 1'b0, 5'd3, '0, '0);
      idle(3);
      fork
         do_req(0, 1'b0, 5'd4, '0, '0);
         do_req(1, 1'b0, 5'd6, '0, '0);
      join

      // Write by port 1 followed immediately by port-0 read of same address
      do_req(1, 1'b1, 5'd31, 9'h0FF, 4'hF);
      do_req(0, 1'b0, 5'd31, '0, '0);
      idle(2);

      // Partial-mask write then read back
      do_req(1, 1'b1, 5'd31, 9'h100, 4'b1010);
      do_req(1, 1'b0, 5'd31, '0, '0);
      idle(2);

      // Reset between a read accept and its response
      do_req(0, 1'b0, 5'd31, '0, '0);
      #1;
      apply_reset();
      fork
         do_req(0, 1'b0, 5'd17, '0, '0);
         do_req(1, 1'b0, 5'd18, '0, '0);
      join

      // Randomized traffic on both ports
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               idle($urandom_range(0, 2));
               do_req(0, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), MASK_W'($urandom));
            end
         end
         begin
            for (int i = 0; i < 150; i++) begin
               idle($urandom_range(0, 2));
               do_req(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), MASK_W'($urandom));
            end
         end
      join

      idle(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending_responses act=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one sky130_sram_1rw_tiny single-port macro between two requester ports (req0, req1).
- Uses round-robin arbitration and one access per clock.
- The macro inputs are driven combinationally from the granted request, so the macro captures them on the same rising edge as the handshake.
- Read data returns on a per-port response strobe one cycle later. Sits between the macro and the TT pin-level or user logic.

Parameters:
- ADDR_W, 5, macro address width (DEPTH = 2**ADDR_W = 32 words)
- DATA_W, 9, macro data width
- MASK_W, 4, macro write-mask width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  (N=0,1) request valid
- reqN_ready  out  1  request accepted at this edge when valid&ready
- reqN_we  in  1  1=write, 0=read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- reqN_wmask  in  MASK_W  write byte-lane mask
- rspN_valid  out  1  read data valid, 1-cycle pulse
- rspN_rdata  out  DATA_W  read data, valid only while rspN_valid
- sram_csb  out  1  macro chip select, active-low
- sram_web  out  1  macro write enable, active-low
- sram_wmask  out  MASK_W  to macro wmask0
- sram_addr  out  ADDR_W  to macro addr0
- sram_din  out  DATA_W  to macro din0
- sram_dout  in  DATA_W  from macro dout0
- busy  out  1  high while not in RUN

Behaviour:
- Reset values:
  - reqN_ready=0, rspN_valid=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
  - Priority pointer points to req0; busy=1 only if INIT is entered.
- States: INIT (feature only) and RUN. With the feature off, the block leaves reset directly in RUN.
- Grant in RUN, combinational:
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the port the pointer favours.
  - reqN_ready = grant==N; at most one ready high per cycle.
- Pointer update: on an accepted handshake the pointer moves to favour the other port. No handshake -> pointer holds.
- SRAM drive:
  - With a grant: sram_csb=0, sram_web=~we, sram_addr/din/wmask come from the granted port.
  - No grant: sram_csb=1, sram_web=1, other outputs 0.
  - For reads, sram_wmask=0.
- Read response:
  - Accepted read at edge k -> rspN_valid=1 for the cycle after edge k, for the requesting port only.
  - rspN_rdata = sram_dout (combinational pass) while valid; 0 otherwise.
  - Back-to-back reads give back-to-back responses. Read latency is exactly 1 cycle.
- Writes: no response; complete at the accept edge. A read of the same address accepted on the next edge returns the new data.
- Simultaneous events: a port may issue a new request in the same cycle its previous read response is valid.
- Requesters must hold valid and payload stable until accepted.
- Async reset mid-operation:
  - Drops any pending response (no rsp pulse after reset).
  - Resets the pointer to req0.
  - Re-enters INIT if compiled in.

Optional Feature:
- Macro: SRAM_ARB_INIT_CLEAR_EN.
- Defined:
  - After reset the FSM is in INIT. A counter addresses 0..DEPTH-1 and writes 0 with mask all-ones, one word per cycle.
  - In INIT: busy=1 and both readies=0.
  - After address DEPTH-1 is written (DEPTH cycles), the FSM moves to RUN and busy=0.
  - Counter wrap is not allowed.
- Undefined: no INIT state or counter. Macro contents after power-up are undefined, busy is tied 0, and the block is in RUN from the first edge after rst_n rises.

Decomposition:
- Package sram_arb_pkg:
  - ADDR_W, DATA_W, MASK_W, DEPTH constants.
  - State enum {ST_INIT, ST_RUN}.
  - WMASK_ALL constant.
- Sub-module rr_arb2: 2-way round-robin grant and pointer register, inputs valid[1:0] and accept, output grant[1:0].

Test Plan:
- Single write then read: req0 writes addr 5 data 0x1A5 mask 4'hF, then reads addr 5 -> rsp0_valid pulses exactly one cycle after read accept, rsp0_rdata=0x1A5; rsp1_valid stays 0.
- Contention: both ports hold valid reads for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; each port sees 3 responses, each 1 cycle after its accept.
- Idle gap: no valid for 3 cycles -> sram_csb=1 and sram_web=1 in all 3 cycles; pointer unchanged, so the next simultaneous request goes to the previously favoured port.
- Same-address write/read: req1 writes addr 31 = 0x0FF at edge k; req0 reads addr 31 at edge k+1 -> rsp0_rdata=0x0FF at cycle k+2.
- Reset mid-read: rst_n asserted between read accept and response -> rspN_valid stays 0, all outputs take reset values immediately (async), pointer returns to req0.
- With SRAM_ARB_INIT_CLEAR_EN: busy=1 and readies=0 for 32 cycles after reset with csb=0/web=0 and addr stepping 0..31; a subsequent read of addr 17 returns 0x000.
